// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch (I)
// and data (D) ports. D has fixed priority; a wait counter forces an I grant
// after MAX_WAIT contended D grants. A watchdog aborts accesses that never
// complete and reports them through err.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,   // 1..15
  parameter int TIMEOUT  = 64   // 2..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic [7:0] timer;
  logic       grant_i, grant_d, busy, finish, timed_out;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // Combinational stall: the pipeline holds while a request is pending and
  // its completion pulse has not arrived yet.
  assign i_stall = i_req & ~i_ready;
  assign d_stall = d_req & ~d_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: arbitration in IDLE, completion/watchdog in BUSY.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || wait_cnt < MAX_WAIT_C)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (timer == TIMER_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      // Requests are ignored here so a requester that has not yet seen its
      // ready pulse is never granted twice.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fairness counter and watchdog timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      timer    <= '0;
    end else begin
      if (grant_i)
        wait_cnt <= '0;
      else if (grant_d && i_req && wait_cnt != MAX_WAIT_C)
        wait_cnt <= wait_cnt + 4'd1;

      if (grant_i || grant_d) timer <= '0;
      else if (busy)          timer <= timer + 8'd1;
    end
  end

  // Memory-side registers: request fields are latched at grant, so requester
  // changes during BUSY have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= grant_i || grant_d || (busy && !finish);
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
      end
    end
  end

  // Requester-side completion: one-cycle ready/err pulses in DONE; read data
  // of the port not being serviced holds its previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= (state == BUSY_I) && finish;
      d_ready <= (state == BUSY_D) && finish;
      err     <= timed_out;
      if (state == BUSY_I && finish) i_rdata <= timed_out ? '0 : mem_rdata;
      if (state == BUSY_D && finish) d_rdata <= timed_out ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_ready, i_stall;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_ready, d_stall;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_req, mem_we, mem_ready, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Memory responder state (advanced inside step()).
  bit resp_en = 1'b0;
  int resp_cnt = 0;
  int resp_lat = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (resp_en) begin
      if (mem_req) begin
        if (resp_cnt >= resp_lat) begin
          mem_ready = 1'b1;
          mem_rdata = hash(mem_addr);
        end else begin
          mem_ready = 1'b0;
        end
        resp_cnt++;
      end else begin
        mem_ready = 1'b0;
        resp_cnt  = 0;
        resp_lat  = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step();
    step();
    checks++;
    if ({mem_req, mem_we, i_ready, d_ready, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, i_ready, d_ready, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    rst = 1'b0;
    step();
    // Reset in the middle of a fetch.
    i_req = 1'b1; i_addr = 32'h40;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL midrst_busy: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, i_ready, err} !== 3'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_async: got req=%b rdy=%b err=%b addr=%h want 0", mem_req, i_ready, err, mem_addr);
    end
    i_req = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (i_ready !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet: got rdy=%b req=%b err=%b want 0", i_ready, mem_req, err);
      end
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    checks++;
    if (i_stall !== 1'b1) begin
      errors++; $display("FAIL fetch_stall0: got %b want 1", i_stall);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || i_ready !== 1'b0 || i_stall !== 1'b1) begin
      errors++; $display("FAIL fetch_busy1: got req=%b addr=%h we=%b rdy=%b stall=%b", mem_req, mem_addr, mem_we, i_ready, i_stall);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || i_ready !== 1'b0 || i_stall !== 1'b1) begin
      errors++; $display("FAIL fetch_busy2: got req=%b rdy=%b stall=%b want 1 0 1", mem_req, i_ready, i_stall);
    end
    mem_ready = 1'b1; mem_rdata = 32'h8C020004;
    step();
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== 32'h8C020004 || i_stall !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL fetch_done: got rdy=%b data=%h stall=%b req=%b err=%b want 1 8c020004 0 0 0",
                         i_ready, i_rdata, i_stall, mem_req, err);
    end
    mem_ready = 1'b0; i_req = 1'b0;
    step();
    checks++;
    if (i_ready !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse: got i_ready=%b want 0", i_ready);
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h2000 || d_ready !== 1'b0) begin
        errors++; $display("FAIL store_busy%0d: got req=%b we=%b wd=%h addr=%h rdy=%b", k, mem_req, mem_we, mem_wdata, mem_addr, d_ready);
      end
      if (k == 0) d_wdata = 32'hDEADBEEF;  // must not leak into the access
      if (k == 3) begin mem_ready = 1'b1; mem_rdata = 32'h0; end
      step();
    end
    checks++;
    if (d_ready !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL store_done: got rdy=%b err=%b req=%b want 1 0 0", d_ready, err, mem_req);
    end
    mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    checks++;
    if (d_ready !== 1'b0) begin
      errors++; $display("FAIL store_pulse: got d_ready=%b want 0", d_ready);
    end
  endtask

  task automatic test_contention();
    bit got_i [10];
    int n = 0;
    int cyc = 0;
    logic prev_req = 1'b0;
    do_reset();
    resp_en = 1'b1;
    i_addr = 32'h1000; d_addr = 32'h3000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    while (n < 10 && cyc < 300) begin
      step();
      cyc++;
      if (mem_req && !prev_req) begin
        got_i[n] = (mem_addr == 32'h1000);
        if (got_i[n]) begin
          checks++;
          if (dut.wait_cnt !== 4'd0) begin
            errors++; $display("FAIL cont_waitclr: got wait_cnt=%0d want 0", dut.wait_cnt);
          end
        end
        n++;
      end
      prev_req = mem_req;
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL cont_timeout: got %0d grants want 10", n);
    end
    // I is forced after every MAX_WAIT consecutive contended D grants.
    for (int g = 0; g < n; g++) begin
      checks++;
      if (got_i[g] !== ((g % (MAX_WAIT + 1)) == MAX_WAIT)) begin
        errors++; $display("FAIL cont_order%0d: got %s want %s", g, got_i[g] ? "I" : "D",
                           ((g % (MAX_WAIT + 1)) == MAX_WAIT) ? "I" : "D");
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 8; k++) step();
    resp_en = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    step();
    while (mem_req && cnt < 300) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt != TIMEOUT) begin
      errors++; $display("FAIL tmo_cycles: got %0d want %0d", cnt, TIMEOUT);
    end
    checks++;
    if (d_ready !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_done: got rdy=%b err=%b data=%h want 1 1 0", d_ready, err, d_rdata);
    end
    d_req = 1'b0;
    step();
    checks++;
    if (err !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse: got err=%b rdy=%b want 0 0", err, d_ready);
    end
    resp_en = 1'b1;
    i_req = 1'b1; i_addr = 32'h80;
    cnt = 0;
    while (!i_ready && cnt < 20) begin cnt++; step(); end
    checks++;
    if (i_ready !== 1'b1 || err !== 1'b0 || i_rdata !== hash(32'h80)) begin
      errors++; $display("FAIL tmo_next: got rdy=%b err=%b data=%h want 1 0 %h", i_ready, err, i_rdata, hash(32'h80));
    end
    i_req = 1'b0;
    step();
    step();
    resp_en = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_withdraw_done();
    i_req = 1'b1; i_addr = 32'h200;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL wd_busy: got req=%b addr=%h want 1 200", mem_req, mem_addr);
    end
    d_req = 1'b0; d_we = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    step();
    checks++;
    if (i_ready !== 1'b1 || mem_req !== 1'b0 || i_rdata !== 32'h11112222) begin
      errors++; $display("FAIL wd_done: got rdy=%b req=%b data=%h want 1 0 11112222", i_ready, mem_req, i_rdata);
    end
    mem_ready = 1'b0;  // i_req stays high through DONE
    step();
    checks++;
    if (mem_req !== 1'b0 || i_ready !== 1'b0) begin
      errors++; $display("FAIL wd_idle: got req=%b rdy=%b want 0 0", mem_req, i_ready);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
      errors++; $display("FAIL wd_regrant: got req=%b addr=%h we=%b want 1 200 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1; mem_rdata = 32'h33334444;
    step();
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== 32'h33334444) begin
      errors++; $display("FAIL wd_second: got rdy=%b data=%h want 1 33334444", i_ready, i_rdata);
    end
    mem_ready = 1'b0; i_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    int         wcnt = 0;
    logic [31:0] exp_i = 32'h0;
    logic [31:0] exp_d = 32'h0;
    bit          d_known = 1'b1;
    do_reset();
    resp_en = 1'b1;
    step();
    for (int t = 0; t < 40; t++) begin
      bit ir, dr, dwe, win_d;
      logic [31:0] ia, da, dwd, waddr;
      int n;
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      ia  = $urandom & 32'hFFFF_FFFC;
      da  = ($urandom & 32'hFFFF_FFFC) ^ 32'h1;  // odd: never equals ia
      dwe = 1'($urandom_range(0, 1));
      dwd = $urandom;
      // Reference: D wins unless I has waited through MAX_WAIT contended D grants.
      win_d = dr && (!ir || wcnt < MAX_WAIT);
      if (win_d && ir) wcnt = (wcnt + 1 > MAX_WAIT) ? MAX_WAIT : wcnt + 1;
      else if (!win_d) wcnt = 0;
      waddr = win_d ? da : ia;

      i_req = ir; i_addr = ia;
      d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd;
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== waddr || mem_we !== (win_d && dwe)) begin
        errors++; $display("FAIL rnd%0d_grant: got req=%b addr=%h we=%b want 1 %h %b", t, mem_req, mem_addr, mem_we, waddr, win_d && dwe);
      end
      if (win_d && dwe) begin
        checks++;
        if (mem_wdata !== dwd) begin
          errors++; $display("FAIL rnd%0d_wdata: got %h want %h", t, mem_wdata, dwd);
        end
      end
      n = 0;
      while (!(win_d ? d_ready : i_ready) && n < 20) begin n++; step(); end
      checks++;
      if ((win_d ? d_ready : i_ready) !== 1'b1 || (win_d ? i_ready : d_ready) !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_ready: got i=%b d=%b err=%b want win_d=%b", t, i_ready, d_ready, err, win_d);
      end
      if (win_d) begin
        d_known = !dwe;
        exp_d = hash(da);
      end else begin
        exp_i = hash(ia);
      end
      checks++;
      if (i_rdata !== exp_i) begin
        errors++; $display("FAIL rnd%0d_irdata: got %h want %h", t, i_rdata, exp_i);
      end
      if (d_known) begin
        checks++;
        if (d_rdata !== exp_d) begin
          errors++; $display("FAIL rnd%0d_drdata: got %h want %h", t, d_rdata, exp_d);
        end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      step();
    end
    resp_en = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_withdraw_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
